ct_f_spsram_1024x92_ctrl: RTL
=============================

Name: ct_f_spsram_1024x92_ctrl

Overview:
- Initiator-side controller for the 1024x92 single-port FPGA SRAM wrapper. It drives that wrapper's A/CEN/GWEN/WEN/D pins and captures its Q output.
- Turns a valid/ready request stream into SRAM accesses and returns read data through a 2-entry response buffer with valid/ready backpressure.
- After reset, and on demand, it runs a zero-fill sweep of all entries.
- Sits between cache/array logic and the SRAM macro.

Parameters:
ADDR_WIDTH, 10, SRAM address width; ENTRIES = 2^ADDR_WIDTH
DATA_WIDTH, 92, SRAM word width
WRAP_SIZE, 23, bits per write lane; LANES = DATA_WIDTH/WRAP_SIZE = 4

Ports:
forever_cpuclk  in  1  clock
cpurst_b  in  1  synchronous active-low reset
init_start  in  1  pulse: request zero-fill sweep
init_busy  out  1  sweep in progress
req_vld  in  1  request valid
req_rdy  out  1  request ready
req_wr  in  1  1=write, 0=read
req_addr  in  ADDR_WIDTH  request address
req_wdata  in  DATA_WIDTH  write data
req_wmask  in  LANES  per-lane write enable, 1=write lane
rsp_vld  out  1  read response valid
rsp_rdy  in  1  response ready
rsp_rdata  out  DATA_WIDTH  read data
sram_a  out  ADDR_WIDTH  SRAM address
sram_cen  out  1  SRAM chip enable, active low
sram_gwen  out  1  SRAM global write enable, active low
sram_wen  out  DATA_WIDTH  SRAM bit write enables, active low
sram_d  out  DATA_WIDTH  SRAM write data
sram_q  in  DATA_WIDTH  SRAM read data, valid the cycle after the read access

Behaviour:
- Reset and clocking: one clock, forever_cpuclk; reset is cpurst_b, synchronous, active-low.
- States: INIT (sweep) and RUN. Reset value is INIT, with sweep counter=0, response FIFO empty and in-flight flag=0.
- Output values while cpurst_b=0:
  - sram_cen=1, sram_gwen=1, sram_wen=all ones, sram_a=0, sram_d=0.
  - req_rdy=0, rsp_vld=0, rsp_rdata=0, init_busy=1.
- INIT:
  - Each cycle: sram_cen=0, sram_gwen=0, sram_wen=0, sram_d=0, sram_a=counter; counter increments.
  - After address ENTRIES-1 is written, go to RUN next cycle. A sweep is exactly ENTRIES cycles.
  - init_busy=1 and req_rdy=0 throughout. init_start is ignored.
- RUN, init_start=1: go to INIT next cycle with counter=0. req_rdy=0 this cycle, so init_start wins over a simultaneous request.
- req_rdy = RUN && !init_start && (fifo_cnt + inflight - (rsp_vld&&rsp_rdy)) < 2. It is the same for reads and writes.
- Accepted request (req_vld&&req_rdy): the SRAM pins are driven combinationally in the same cycle.
  - Read: sram_cen=0, sram_gwen=1, sram_wen=all ones, sram_a=req_addr. Sets inflight for the next cycle.
  - Write: sram_cen=0, sram_gwen=0, sram_a=req_addr, sram_d=req_wdata. sram_wen lane i bits [WRAP_SIZE*i+WRAP_SIZE-1 : WRAP_SIZE*i] = ~req_wmask[i]. A write with mask 0 still drives cen=0 with all wen bits 1, so no bits change.
  - No accepted request: sram_cen=1, sram_gwen=1, sram_wen=all ones, sram_a=0, sram_d=0.
- Capture and response latency:
  - inflight=1: sram_q is pushed into the FIFO at the end of that cycle.
  - Read latency is 2: request accepted in cycle N, rsp_vld=1 in cycle N+2 at the earliest.
  - rsp_vld = FIFO non-empty; rsp_rdata = FIFO head. Pop on rsp_vld&&rsp_rdy.
  - A push and a pop in the same cycle are legal; the count is unchanged.
  - Responses return strictly in request order.
- The FIFO never overflows; the credit rule guarantees it. Pending and in-flight responses keep draining during INIT.
- Read-after-write to the same address in consecutive cycles returns the new data: written lanes new, unmasked lanes old.
- Reset asserted mid-sweep or mid-transaction: next cycle is INIT at counter 0, FIFO flushed, in-flight read discarded.

Test Plan:
1. Release cpurst_b -> init_busy=1 for exactly 1024 cycles; sram_a steps 0..1023 with cen=0, gwen=0, wen=0, d=0. Then req_rdy=1. A read of 0x3FF returns rsp_rdata=0 two cycles after accept.
2. Write 0x155 with data 92'h0A5A5A5A5A5A5A5A5A5A5A5 and mask 4'hF, then read 0x155 next cycle -> rsp_vld two cycles after the read accept, with matching data.
3. Start from zeroed 0x010. Write all ones with mask 4'b0101, then read -> bits [22:0] and [68:46] are ones, all other bits 0. During the write, sram_wen lanes 1 and 3 are all ones.
4. Hold rsp_rdy=0 and issue reads to 0x001, 0x002, 0x003 back-to-back -> only two accepted, req_rdy=0 from the third cycle. Raise rsp_rdy -> responses return in order, then the third read is accepted.
5. In RUN, pulse init_start with one read in flight and one response buffered -> both responses delivered intact, sweep runs 1024 cycles, and a read of a previously written address returns 0.
6. Assert cpurst_b=0 for 1 cycle when the sweep is at address 500 -> the sweep restarts at address 0 and init_busy stays 1 for a full 1024 more cycles.

Source files
------------

// File: rtl/ct_f_spsram_1024x92_ctrl.sv
// rtl/ct_f_spsram_1024x92_ctrl.sv - request/response controller with zero-fill sweep for the 1024x92 single-port SRAM
module ct_f_spsram_1024x92_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 92,
  parameter int WRAP_SIZE  = 23,
  localparam int LANES     = DATA_WIDTH / WRAP_SIZE,
  localparam int ENTRIES   = 1 << ADDR_WIDTH
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  init_start,
  output logic                  init_busy,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [LANES-1:0]      req_wmask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ENTRIES - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    inflight_q;
  logic [DATA_WIDTH-1:0]   fifo_mem [2];
  logic                    wr_ptr_q, rd_ptr_q;
  logic [1:0]              fifo_cnt_q;
  logic                    fifo_pop, fifo_push, req_acc;
  logic [2:0]              occupancy;
  logic [DATA_WIDTH-1:0]   wen_lanes;

  // Handshakes: a slot is free when buffered plus in-flight reads, net of this cycle's pop, leave room.
  always_comb begin
    fifo_pop  = rsp_vld && rsp_rdy;
    fifo_push = inflight_q;
    occupancy = {1'b0, fifo_cnt_q} + {2'b0, inflight_q} - {2'b0, fifo_pop};
    req_rdy   = cpurst_b && (state_q == ST_RUN) && !init_start && (occupancy < 3'd2);
    req_acc   = req_vld && req_rdy;
    rsp_vld   = cpurst_b && (fifo_cnt_q != 2'd0);
    rsp_rdata = rsp_vld ? fifo_mem[rd_ptr_q] : '0;
    init_busy = !cpurst_b || (state_q == ST_INIT);
  end

  // State register: sweep counter and INIT/RUN mode.
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: sweep every address once, then serve requests until init_start.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) state_d = ST_RUN;
      end
      default: begin
        if (init_start) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // Expand the per-lane write mask into active-low bit enables.
  always_comb begin
    wen_lanes = '1;
    for (int i = 0; i < LANES; i++) begin
      wen_lanes[i*WRAP_SIZE +: WRAP_SIZE] = {WRAP_SIZE{~req_wmask[i]}};
    end
  end

  // Outputs: SRAM pins follow the sweep or the accepted request, idle otherwise.
  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
    if (cpurst_b) begin
      if (state_q == ST_INIT) begin
        sram_cen  = 1'b0;
        sram_gwen = 1'b0;
        sram_wen  = '0;
        sram_a    = cnt_q;
      end else if (req_acc) begin
        sram_cen = 1'b0;
        sram_a   = req_addr;
        if (req_wr) begin
          sram_gwen = 1'b0;
          sram_wen  = wen_lanes;
          sram_d    = req_wdata;
        end
      end
    end
  end

  // Response bookkeeping: in-flight read flag and 2-entry FIFO pointers/count.
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      inflight_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      inflight_q <= req_acc && !req_wr;
      if (fifo_push) wr_ptr_q <= ~wr_ptr_q;
      if (fifo_pop)  rd_ptr_q <= ~rd_ptr_q;
      fifo_cnt_q <= fifo_cnt_q + {1'b0, fifo_push} - {1'b0, fifo_pop};
    end
  end

  // FIFO storage: capture SRAM read data the cycle after the read access.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst_b && fifo_push) fifo_mem[wr_ptr_q] <= sram_q;
  end

endmodule
